ff_bank: RTL and testbench
==========================

# ff_bank

Parametrised bank of WIDTH flip-flops with run-time-selectable behaviour (D, T, SR, JK). Every mode is reduced to a per-bit toggle vector that drives a shared toggle register, q <= q ^ t, so one storage structure serves all four flip-flop types. It replaces single-bit SR/T flip-flop instances wherever a multi-bit state register with mode control is needed. The block also detects illegal SR inputs (S=R=1), resolves them by a configurable priority, and flags them with a sticky error bit and an optional event counter.

## Interface
Parameters:
- WIDTH, 8, number of flip-flop channels (>=1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- SR_PRIO, 0, S=R=1 resolution in SR mode: 0 = hold, 1 = set wins, 2 = reset wins
- ERR_CNT_W, 8, width of err_cnt (used only with FF_BANK_ERR_CNT_EN)

Ports:
- clock  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset; overrides all other inputs
- en  in  1  global update enable; 0 = every channel holds
- mode  in  2  00 D, 01 T, 10 SR, 11 JK; applies to all channels; sampled every cycle
- a  in  WIDTH  D / T / S / J input per channel
- b  in  WIDTH  R / K input per channel; ignored in D and T modes
- err_clr  in  1  clears sr_err and err_cnt
- q  out  WIDTH  registered state
- q_bar  out  WIDTH  registered complement of q
- sr_err  out  1  sticky illegal-SR flag
- err_cnt  out  ERR_CNT_W  saturating illegal-SR cycle count (present only with FF_BANK_ERR_CNT_EN)

## Operation
- Toggle vector t per bit:
  - D: t = a ^ q
  - T: t = a
  - SR: t = (a & ~q) | (b & q) for bits where a&b == 0. Bits with a&b == 1 follow SR_PRIO: hold gives t=0; set gives t=~q; reset gives t=q.
  - JK: t = (a & ~q) | (b & q); J=K=1 toggles the bit.
- Update: if en, q <= q ^ t and q_bar <= q_bar ^ t; otherwise both hold.
- q_bar is held in its own register, not derived combinationally. The invariant q_bar == ~q holds on every cycle.
- Illegal event: en & (mode == 10) & |(a & b). A cycle counts as one event regardless of how many bits are illegal.
- sr_err sets on an illegal event and clears on err_clr. If both occur in the same cycle, the set wins (sr_err = 1).
- Mode changes take effect on the next edge. There is no per-mode internal state, so a change needs no flush.
- err_clr acts even when en=0.

## Timing
- Reset (rst=1 at posedge): q = RST_VAL, q_bar = ~RST_VAL, sr_err = 0, err_cnt = 0. This takes effect regardless of en, mode or err_clr.
- Latency is 1 cycle: inputs sampled at edge N appear on q and q_bar after edge N.
- Every bit of q updates on every enabled edge. There are no multi-cycle paths.
- rst asserted mid-sequence discards any pending toggles. The first post-reset update acts on RST_VAL.
- sr_err and err_cnt update on the same edge as the offending q update.

## Configuration
- FF_BANK_ERR_CNT_EN defined:
  - err_cnt port and counter are present.
  - The counter increments by 1 per illegal event and saturates at 2^ERR_CNT_W-1.
  - err_clr resets it to 0. If err_clr and an illegal event occur in the same cycle, the count becomes 1.
- Not defined: the err_cnt port and counter are absent. sr_err behaviour is unchanged.

## Test plan
- Reset, D mode, load: rst=1 with RST_VAL=8'h00, then rst=0, en=1, mode=00, a=8'hA5 -> q=8'hA5, q_bar=8'h5A one cycle later; with en=0 and a=8'hFF the next cycle, q stays 8'hA5.
- T mode: from q=8'hA5, mode=01, a=8'h0F for 2 cycles -> q=8'hAA, then q=8'hA5.
- SR with legal inputs and JK toggle: from q=8'h00, mode=10, a=8'h03, b=8'h00 -> q=8'h03; then mode=11, a=b=8'h01 -> q=8'h02; sr_err stays 0 throughout.
- Illegal SR, one run per SR_PRIO: from q=8'hF0, mode=10, a=b=8'hFF:
  - SR_PRIO=0 -> q=8'hF0
  - SR_PRIO=1 -> q=8'hFF
  - SR_PRIO=2 -> q=8'h00
  - In all three, sr_err=1 next cycle and stays 1 after inputs return to 0, until err_clr.
- Error counter (FF_BANK_ERR_CNT_EN, ERR_CNT_W=2): 5 consecutive illegal cycles -> err_cnt reads 1,2,3,3,3; err_clr together with an illegal event -> err_cnt=1, sr_err=1; err_clr alone -> err_cnt=0, sr_err=0.
- Reset mid-operation: T mode with a=8'hFF running, rst=1 for one cycle -> q=RST_VAL, q_bar=~RST_VAL, sr_err=0, err_cnt=0; a checker asserts q_bar == ~q on every cycle of every scenario.

Source files
------------

// File: rtl/ff_bank.sv
// Bank of WIDTH flip-flops with run-time D/T/SR/JK mode; each mode becomes a toggle vector. Optional err counter: FF_BANK_ERR_CNT_EN.
// Latency: 1 cycle from input sample to q/q_bar/sr_err/err_cnt.
// Backpressure: none; en gates every update, rst overrides everything.
module ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
  parameter int               SR_PRIO   = 0,
  parameter int               ERR_CNT_W = 8
) (
  input  logic                 clock_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 err_clr_i,
  output logic [WIDTH-1:0]     q_o,
  output logic [WIDTH-1:0]     q_bar_o,
`ifdef FF_BANK_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
  output logic                 sr_err_o
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b10;
  localparam logic [1:0] MODE_JK = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_bar_q, q_bar_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] illegal_bits;
  logic [WIDTH-1:0] jk_toggle;
  logic             illegal_evt;
  logic             sr_err_q, sr_err_d;

  // Reduce the selected flip-flop behaviour to a per-bit toggle vector.
  always_comb begin
    illegal_bits = a_i & b_i;
    jk_toggle    = (a_i & ~q_q) | (b_i & q_q);
    toggle       = '0;
    case (mode_i)
      MODE_D:  toggle = a_i ^ q_q;
      MODE_T:  toggle = a_i;
      MODE_SR: begin
        // S=R=1 bits would look like a JK toggle; mask them and apply the priority instead.
        toggle = jk_toggle & ~illegal_bits;
        if (SR_PRIO == 1) toggle = toggle | (illegal_bits & ~q_q);
        else if (SR_PRIO == 2) toggle = toggle | (illegal_bits & q_q);
      end
      MODE_JK: toggle = jk_toggle;
      default: toggle = '0;
    endcase
  end

  // One event per cycle, no matter how many bits collide.
  assign illegal_evt = en_i && (mode_i == MODE_SR) && (|illegal_bits);

  // Next state of the shared toggle registers and the sticky error flag.
  always_comb begin
    q_d      = q_q;
    q_bar_d  = q_bar_q;
    if (en_i) begin
      q_d     = q_q ^ toggle;
      q_bar_d = q_bar_q ^ toggle;
    end
    sr_err_d = sr_err_q;
    if (illegal_evt)    sr_err_d = 1'b1;
    else if (err_clr_i) sr_err_d = 1'b0;
  end

  // State registers; q_bar kept in its own flops so it is a clean registered output.
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      q_q      <= RST_VAL;
      q_bar_q  <= ~RST_VAL;
      sr_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      q_bar_q  <= q_bar_d;
      sr_err_q <= sr_err_d;
    end
  end

  assign q_o      = q_q;
  assign q_bar_o  = q_bar_q;
  assign sr_err_o = sr_err_q;

`ifdef FF_BANK_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating event count; a clear coinciding with an event leaves a count of one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (illegal_evt) begin
      if (err_clr_i)               err_cnt_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      else if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end else if (err_clr_i) begin
      err_cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: three instances, one per SR_PRIO, share all stimulus.
// Outputs sampled 1 time unit after the rising edge; q_bar/q invariant checked on every falling edge.
// Err counter checks compile in only when FF_BANK_ERR_CNT_EN is defined.
module tb_ff_bank;

  logic       clock = 1'b0;
  logic       rst = 1'b0, en = 1'b0, err_clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00, b = 8'h00;

  logic [7:0] q0, q1, q2, qb0, qb1, qb2;
  logic       e0, e1, e2;
`ifdef FF_BANK_ERR_CNT_EN
  logic [1:0] c0, c1, c2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit inv_en   = 1'b0;

  always #5 clock = ~clock;

  ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_PRIO(0), .ERR_CNT_W(2)) u0 (
    .clock_i(clock), .rst_i(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b),
    .err_clr_i(err_clr), .q_o(q0), .q_bar_o(qb0),
`ifdef FF_BANK_ERR_CNT_EN
    .err_cnt_o(c0),
`endif
    .sr_err_o(e0));
  ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_PRIO(1), .ERR_CNT_W(2)) u1 (
    .clock_i(clock), .rst_i(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b),
    .err_clr_i(err_clr), .q_o(q1), .q_bar_o(qb1),
`ifdef FF_BANK_ERR_CNT_EN
    .err_cnt_o(c1),
`endif
    .sr_err_o(e1));
  ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_PRIO(2), .ERR_CNT_W(2)) u2 (
    .clock_i(clock), .rst_i(rst), .en_i(en), .mode_i(mode), .a_i(a), .b_i(b),
    .err_clr_i(err_clr), .q_o(q2), .q_bar_o(qb2),
`ifdef FF_BANK_ERR_CNT_EN
    .err_cnt_o(c2),
`endif
    .sr_err_o(e2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    chk({tag, " q0"}, {24'h0, q0}, {24'h0, x0});
    chk({tag, " q1"}, {24'h0, q1}, {24'h0, x1});
    chk({tag, " q2"}, {24'h0, q2}, {24'h0, x2});
    chk({tag, " qbar0"}, {24'h0, qb0}, {24'h0, ~x0});
  endtask

  task automatic chk_err(input string tag, input logic x);
    chk({tag, " sr_err"}, {29'h0, e0, e1, e2}, {29'h0, x, x, x});
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] x);
`ifdef FF_BANK_ERR_CNT_EN
    chk({tag, " err_cnt"}, {26'h0, c0, c1, c2}, {26'h0, x, x, x});
`else
    chk({tag, " sr_err(nocnt)"}, {31'h0, e0}, {31'h0, (x != 2'd0)});
`endif
  endtask

  // q_bar must be the exact complement of q on every cycle.
  always @(negedge clock) begin
    if (inv_en) begin
      chk("inv u0", {24'h0, qb0}, {24'h0, ~q0});
      chk("inv u1", {24'h0, qb1}, {24'h0, ~q1});
      chk("inv u2", {24'h0, qb2}, {24'h0, ~q2});
    end
  end

  initial begin
    // Reset with competing inputs active.
    rst = 1'b1; en = 1'b1; mode = 2'b01; a = 8'hFF; b = 8'hFF; err_clr = 1'b0;
    step();
    chk_q("reset", 8'h00, 8'h00, 8'h00);
    chk_err("reset", 1'b0);
    chk_cnt("reset", 2'd0);
    inv_en = 1'b1;

    // D load, then hold with en=0.
    rst = 1'b0; en = 1'b1; mode = 2'b00; a = 8'hA5; b = 8'h00;
    step(); chk_q("d load", 8'hA5, 8'hA5, 8'hA5);
    en = 1'b0; a = 8'hFF;
    step(); chk_q("en hold", 8'hA5, 8'hA5, 8'hA5);

    // T mode toggles.
    en = 1'b1; mode = 2'b01; a = 8'h0F;
    step(); chk_q("t1", 8'hAA, 8'hAA, 8'hAA);
    step(); chk_q("t2", 8'hA5, 8'hA5, 8'hA5);

    // Legal SR, then JK toggle.
    mode = 2'b00; a = 8'h00;
    step(); chk_q("d zero", 8'h00, 8'h00, 8'h00);
    mode = 2'b10; a = 8'h03; b = 8'h00;
    step(); chk_q("sr set", 8'h03, 8'h03, 8'h03); chk_err("sr legal", 1'b0);
    mode = 2'b11; a = 8'h01; b = 8'h01;
    step(); chk_q("jk tog", 8'h02, 8'h02, 8'h02); chk_err("jk", 1'b0);
    mode = 2'b11; a = 8'h00; b = 8'h02;
    step(); chk_q("jk rst", 8'h00, 8'h00, 8'h00);

    // Illegal SR from F0, resolved per instance priority.
    mode = 2'b00; a = 8'hF0; b = 8'h00;
    step(); chk_q("d f0", 8'hF0, 8'hF0, 8'hF0);
    mode = 2'b10; a = 8'hFF; b = 8'hFF;
    step(); chk_q("sr ill", 8'hF0, 8'hFF, 8'h00); chk_err("sr ill", 1'b1); chk_cnt("sr ill", 2'd1);
    a = 8'h00; b = 8'h00;
    step(); chk_q("sr idle", 8'hF0, 8'hFF, 8'h00); chk_err("sticky", 1'b1);

    // Clear works with en=0; illegal inputs with en=0 do not count.
    en = 1'b0; err_clr = 1'b1;
    step(); chk_err("clr en0", 1'b0); chk_cnt("clr en0", 2'd0);
    err_clr = 1'b0; a = 8'hFF; b = 8'hFF;
    step(); chk_err("ill en0", 1'b0); chk_cnt("ill en0", 2'd0);
    chk_q("ill en0", 8'hF0, 8'hFF, 8'h00);

    // Saturating counter: 1,2,3,3,3.
    en = 1'b1;
    step(); chk_cnt("cnt1", 2'd1); chk_err("cnt1", 1'b1);
`ifdef FF_BANK_ERR_CNT_EN
    step(); chk_cnt("cnt2", 2'd2);
    step(); chk_cnt("cnt3", 2'd3);
    step(); chk_cnt("cnt4", 2'd3);
    step(); chk_cnt("cnt5", 2'd3);
`endif
    // Clear together with an event, then clear alone.
    err_clr = 1'b1;
    step(); chk_cnt("clr+ill", 2'd1); chk_err("clr+ill", 1'b1);
    a = 8'h00; b = 8'h00;
    step(); chk_cnt("clr", 2'd0); chk_err("clr", 1'b0);
    err_clr = 1'b0;

    // Reset mid-run in T mode, after re-arming sr_err.
    mode = 2'b01; a = 8'hFF;
    step(); chk_q("t run", 8'h0F, 8'h00, 8'hFF);
    mode = 2'b10; a = 8'hFF; b = 8'hFF;
    step(); chk_err("rearm", 1'b1);
    mode = 2'b01; b = 8'h00; rst = 1'b1;
    step(); chk_q("mid rst", 8'h00, 8'h00, 8'h00); chk_err("mid rst", 1'b0); chk_cnt("mid rst", 2'd0);
    rst = 1'b0;
    step(); chk_q("post rst", 8'hFF, 8'hFF, 8'hFF);

    @(negedge clock);
    inv_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
